stbus_tx: RTL and testbench
===========================

# stbus_tx

Master-side ST-bus transmitter. It generates the 8 kHz frame pulse `f0` from the 4.096 MHz `c4` clock and serialises 32 channel bytes per frame onto a 2.048 Mbit/s TDM data line. It is the driving end of the `f0`/`c4` timing that the converter block consumes. Host logic loads bytes into a pending buffer, and a commit makes them live at the next frame boundary.

## Interface
Parameters:
- `IDLE_BYTE`, default 8'hFF: reset/idle contents of every channel in both buffers.

Ports:
- `c4` in 1: 4.096 MHz system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: write strobe. Writes `wr_data` into pending channel `wr_ch`.
- `wr_ch` in 5: channel index 0..31.
- `wr_data` in 8: channel byte. Bit 7 is transmitted first.
- `commit` in 1: one-cycle request to make the pending buffer active at the next frame boundary.
- `f0` out 1: frame pulse, active low, one `c4` period per frame.
- `dout` out 1: serial TDM data.
- `frame_start` out 1: high for the single cycle where `f0`=0.
- `swapped` out 1: one-cycle pulse in the cycle a commit took effect.
- `commit_pend` out 1: high from an accepted commit until it is applied.

## Operation
Frame counter:
- `cnt` is 9 bits, 0..511, and increments every `c4` edge.
- 511 wraps to 0. Frame length is 512 `c4` periods = 125 µs.
- Reset value is `cnt`=511, so the first edge after reset release enters `cnt`=0.

Registered outputs, aligned to `cnt` (all change on the same edge that loads `cnt`):
- `f0` = 0 and `frame_start` = 1 exactly while `cnt`==0.
- While `cnt`==k, `dout` = bit (7 − k[3:1]) of `active[k[8:4]]`. Each bit occupies 2 `c4` periods, so a channel spans 16 cycles.
- Channel 0 bit 7 occupies `cnt` 0..1. Channel 31 bit 0 occupies `cnt` 510..511.

Buffers:
- `pending[0..31]` and `active[0..31]` are each 32 × 8-bit registers.
- `wr_en` writes `pending[wr_ch]` on the clock edge. It never affects `active` directly.
- Back-to-back writes are allowed every cycle. The same channel written twice keeps the last value.

Commit flow:
- `commit`=1 sets `commit_pend`. A repeat commit while already pending is absorbed, with no error.
- On the edge where `cnt` goes 511→0 with `commit_pend`=1:
  - `active` ← `pending` (all 32 bytes at once).
  - `commit_pend` ← 0.
  - `swapped` = 1 for that `cnt`==0 cycle.
- The new data is therefore first visible as channel 0 bit 7 of that frame. A frame is never mixed between old and new data.

Simultaneous events:
- `wr_en` on the wrap edge: the copy takes the pre-write `pending`. The written byte stays in `pending` and waits for a later commit.
- `commit` on the wrap edge: it is not applied at this wrap. `commit_pend` becomes 1 and is applied at the next wrap, 512 cycles later.
- `commit` on the wrap edge while `commit_pend` was already 1: the copy occurs and `commit_pend` stays 1, because the new commit is re-armed.

Reset:
- Values: `f0`=1, `frame_start`=0, `swapped`=0, `commit_pend`=0, `dout`=1, all `pending`/`active` = `IDLE_BYTE`.
- Assertion mid-frame forces these values immediately. Any in-flight commit and written pending data are discarded.

## Timing
- The frame period is exactly 512 cycles, with no drift. `f0` low width is exactly 1 cycle.
- Write-to-line latency is bounded by the commit: from `commit` at `cnt`=c (c≠511), data appears at the next `cnt`=0, which is 512−c cycles later.
- The first `f0` low occurs 1 cycle after `rst_n` deasserts.
- No combinational path from any input to any output.

## Test plan
- **Reset/idle:** release `rst_n`, run 1030 cycles.
  - `f0` is low at cycles 1, 513 and 1025 only.
  - `dout` is constant 1.
  - `swapped` and `commit_pend` stay 0.
- **Single channel:** write ch0=8'hA5, commit at `cnt`=100.
  - `commit_pend`=1 until the next `cnt`=0, where `swapped`=1.
  - `dout` over `cnt` 0..15 is 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1.
  - The remaining channels stay 1.
- **Full frame:** write ch n = n for n = 0..31, then commit.
  - The serial capture of the next frame decodes bytes 0x00..0x1F in order.
  - The following frame repeats identically without a further commit.
- **Wrap collisions:** at the cycle where `cnt`=511, assert `wr_en` (ch5=8'h3C) and `commit` together, with `commit_pend` previously 0.
  - The first frame still shows ch5 old value 8'hFF.
  - The frame after shows 8'h3C with `swapped`=1.
- **Reset mid-operation:** commit pending at `cnt`=300, assert `rst_n`=0 for 3 cycles.
  - Outputs take their reset values asynchronously.
  - After release, the frame shows all 8'hFF, `commit_pend`=0, and `f0` is low 1 cycle after release.

Source files
------------

// File: rtl/stbus_tx.sv
// stbus_tx: ST-bus master transmitter.
// Generates the 8 kHz active-low frame pulse f0 from the 4.096 MHz c4 clock and
// serialises 32 channel bytes per 512-cycle frame, MSB first, two c4 periods
// per bit. Host writes land in a pending buffer; a commit copies the whole
// pending buffer into the active buffer on the next frame wrap, so a frame
// never mixes old and new data.
module stbus_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       c4,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_ch,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       f0,
  output logic       dout,
  output logic       frame_start,
  output logic       swapped,
  output logic       commit_pend
);

  localparam int         NUM_CH   = 32;
  localparam logic [8:0] CNT_LAST = 9'd511;
  localparam logic [8:0] CNT_ZERO = 9'd0;

  // Select the serial bit for a bit slot within a channel (slot 0 carries bit 7).
  function automatic logic tx_bit(input logic [7:0] byte_v, input logic [2:0] slot);
    logic [2:0] idx;
    idx = 3'd7 - slot;
    return byte_v[idx];
  endfunction

  // Frame position and its next value.
  logic [8:0] cnt_q;
  logic [8:0] cnt_d;

  // Channel buffers.
  logic [7:0] pending_q [NUM_CH];
  logic [7:0] active_q  [NUM_CH];
  logic [7:0] active_d  [NUM_CH];

  // Commit tracking.
  logic commit_pend_q;
  logic commit_pend_d;
  logic wrap_s;
  logic swap_s;

  // Registered line outputs and their next values.
  logic f0_q;
  logic f0_d;
  logic dout_q;
  logic dout_d;
  logic frame_start_q;
  logic frame_start_d;
  logic swapped_q;

  // Next-state logic: frame count, commit handling and the bit to drive next.
  always_comb begin
    cnt_d  = cnt_q + 9'd1;
    wrap_s = (cnt_q == CNT_LAST);
    swap_s = wrap_s & commit_pend_q;

    // A commit arriving on the wrap edge itself re-arms for the following wrap.
    if (commit) begin
      commit_pend_d = 1'b1;
    end else if (wrap_s) begin
      commit_pend_d = 1'b0;
    end else begin
      commit_pend_d = commit_pend_q;
    end

    // The copy uses the pre-write pending contents, so a write on the wrap
    // edge stays pending for a later commit.
    for (int i = 0; i < NUM_CH; i++) begin
      if (swap_s) begin
        active_d[i] = pending_q[i];
      end else begin
        active_d[i] = active_q[i];
      end
    end

    // Outputs are aligned with the count being loaded, so look at cnt_d and
    // active_d: new data shows up as channel 0 bit 7 of the new frame.
    f0_d          = (cnt_d != CNT_ZERO);
    frame_start_d = (cnt_d == CNT_ZERO);
    dout_d        = tx_bit(active_d[cnt_d[8:4]], cnt_d[3:1]);
  end

  // Frame counter, commit flag and registered line outputs.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= CNT_LAST;
      commit_pend_q <= 1'b0;
      f0_q          <= 1'b1;
      dout_q        <= 1'b1;
      frame_start_q <= 1'b0;
      swapped_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      commit_pend_q <= commit_pend_d;
      f0_q          <= f0_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_start_d;
      swapped_q     <= swap_s;
    end
  end

  // Pending buffer: host writes, one channel per cycle, last write wins.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= IDLE_BYTE;
      end
    end else begin
      if (wr_en) begin
        pending_q[wr_ch] <= wr_data;
      end
    end
  end

  // Active buffer: replaced as a whole only on a frame wrap with a commit pending.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= IDLE_BYTE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= active_d[i];
      end
    end
  end

  assign f0          = f0_q;
  assign dout        = dout_q;
  assign frame_start = frame_start_q;
  assign swapped     = swapped_q;
  assign commit_pend = commit_pend_q;

endmodule

// File: tb/tb_stbus_tx.sv
// Testbench for stbus_tx: directed scenarios plus a randomized phase, all
// checked every cycle against a frame-level reference model.
module tb_stbus_tx;

  logic       c4 = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_ch = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       commit = 1'b0;
  logic       f0;
  logic       dout;
  logic       frame_start;
  logic       swapped;
  logic       commit_pend;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_cnt;
  logic       m_pend;
  logic       m_sw;
  logic [7:0] m_active  [32];
  logic [7:0] m_pending [32];
  logic       cap [512];
  int         t;
  int         lows_total;
  int         low_t [3];
  logic       saw_swap;

  stbus_tx #(.IDLE_BYTE(8'hFF)) dut (
    .c4(c4), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .commit(commit), .f0(f0), .dout(dout), .frame_start(frame_start),
    .swapped(swapped), .commit_pend(commit_pend)
  );

  always #10 c4 = ~c4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d cnt=%0d)", tag, obs, exp, t, m_cnt);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 511;
    m_pend = 1'b0;
    m_sw   = 1'b0;
    t      = 0;
    for (int i = 0; i < 32; i++) begin
      m_active[i]  = 8'hFF;
      m_pending[i] = 8'hFF;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_f0"}, f0, 1'b1);
    chk({tag, "_dout"}, dout, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_sw"}, swapped, 1'b0);
    chk({tag, "_cp"}, commit_pend, 1'b0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check all outputs.
  task automatic step(input logic w, input logic [4:0] ch, input logic [7:0] d, input logic cm);
    logic exp_sw;
    logic exp_dout;
    wr_en = w; wr_ch = ch; wr_data = d; commit = cm;
    @(posedge c4);
    exp_sw = (m_cnt == 511) && m_pend;
    if (exp_sw) begin
      for (int i = 0; i < 32; i++) m_active[i] = m_pending[i];
    end
    if (w) m_pending[ch] = d;
    if (cm) m_pend = 1'b1;
    else if (m_cnt == 511) m_pend = 1'b0;
    m_cnt = (m_cnt + 1) % 512;
    m_sw  = exp_sw;
    t++;
    #1;
    exp_dout = m_active[m_cnt / 16][7 - (m_cnt % 16) / 2];
    chk("f0", f0, (m_cnt != 0));
    chk("frame_start", frame_start, (m_cnt == 0));
    chk("dout", dout, exp_dout);
    chk("swapped", swapped, m_sw);
    chk("commit_pend", commit_pend, m_pend);
    cap[m_cnt] = dout;
    if (f0 === 1'b0) begin
      if (lows_total < 3) low_t[lows_total] = t;
      lows_total++;
    end
    if (swapped === 1'b1) saw_swap = 1'b1;
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  // Advance (at most one frame) until the model position equals target.
  task automatic run_to(input int target);
    for (int i = 0; i < 512 && m_cnt != target; i++) idle();
  endtask

  // Capture one whole frame: ends at cnt 511 with cap[] holding that frame.
  task automatic next_frame();
    run_to(511);
    repeat (512) idle();
  endtask

  function automatic logic [7:0] cap_byte(input int ch);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[7 - b] = cap[ch * 16 + 2 * b];
    return r;
  endfunction

  initial begin
    logic [15:0] pat;
    logic [15:0] exp_pat;

    // Reset state
    model_reset();
    lows_total = 0;
    saw_swap = 1'b0;
    repeat (2) @(posedge c4);
    #1;
    chk_reset("rst0");
    #5 rst_n = 1'b1;

    // Reset/idle: 1030 cycles, f0 low at 1, 513, 1025 only
    lows_total = 0;
    repeat (1030) idle();
    chk("idle_lows", lows_total, 3);
    chk("idle_low0", low_t[0], 1);
    chk("idle_low1", low_t[1], 513);
    chk("idle_low2", low_t[2], 1025);
    chk("idle_noswap", saw_swap, 1'b0);

    // Single channel: ch0=A5, commit at cnt 100
    run_to(50);
    step(1'b1, 5'd0, 8'hA5, 1'b0);
    run_to(100);
    step(1'b0, 5'd0, 8'd0, 1'b1);
    next_frame();
    for (int i = 0; i < 16; i++) pat[15 - i] = cap[i];
    exp_pat = 16'hCC33;
    chk("single_ch0_bits", pat, exp_pat);
    chk("single_ch31", cap_byte(31), 8'hFF);

    // Full frame: ch n = n
    for (int n = 0; n < 32; n++) step(1'b1, n[4:0], n[7:0], 1'b0);
    step(1'b0, 5'd0, 8'd0, 1'b1);
    next_frame();
    for (int n = 0; n < 32; n++) chk("full_f1", cap_byte(n), n);
    next_frame();
    for (int n = 0; n < 32; n++) chk("full_f2", cap_byte(n), n);

    // Reset mid-operation with a commit pending
    step(1'b1, 5'd7, 8'h11, 1'b0);
    run_to(300);
    step(1'b0, 5'd0, 8'd0, 1'b1);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    model_reset();
    repeat (3) begin
      @(posedge c4);
      #1;
      chk_reset("rst_hold");
    end
    #5 rst_n = 1'b1;
    idle();
    chk("rst_f0_first", f0, 1'b0);
    chk("rst_cp", commit_pend, 1'b0);
    next_frame();
    for (int n = 0; n < 32; n++) chk("rst_frame", cap_byte(n), 8'hFF);

    // Wrap collision: write ch5=3C and commit on the cnt=511 cycle
    run_to(511);
    step(1'b1, 5'd5, 8'h3C, 1'b1);
    chk("coll_noswap", swapped, 1'b0);
    repeat (511) idle();
    chk("coll_old", cap_byte(5), 8'hFF);
    chk("coll_pend", commit_pend, 1'b1);
    idle();
    chk("coll_swap", swapped, 1'b1);
    repeat (511) idle();
    chk("coll_new", cap_byte(5), 8'h3C);
    chk("coll_other", cap_byte(4), 8'hFF);

    // Randomized writes and commits
    repeat (3000) begin
      step(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
